// File: rtl/ctrl_sequencer.sv
// ============================================================================
// ctrl_sequencer : hardwired fetch/decode/execute control unit for the bus datapath
// Optional memory-wait watchdog enabled by defining CTRL_WAIT_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ctrl_sequencer #(
  parameter logic [3:0] ALU_ADD        = 4'd0,
  parameter logic [3:0] ALU_SUB        = 4'd1,
  parameter logic [3:0] ALU_AND        = 4'd2,
  parameter logic [3:0] ALU_OR         = 4'd3,
  parameter logic [3:0] ALU_INC        = 4'd4,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_data,
  input  logic        mem_ready,
  output logic [15:0] gpr_in,
  output logic [15:0] gpr_out,
  output logic        hi_in,
  output logic        lo_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        z_in,
  output logic        y_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        hi_out,
  output logic        lo_out,
  output logic        pc_out,
  output logic        z_high_out,
  output logic        z_low_out,
  output logic        mdr_out,
  output logic        inport_out,
  output logic        c_out,
  output logic        read,
  output logic [3:0]  alu_op,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        run,
  output logic        instr_done,
  output logic        illegal,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_F0  = 3'd0,
    S_F1  = 3'd1,
    S_F2  = 3'd2,
    S_DEC = 3'd3,
    S_E3  = 3'd4,
    S_E4  = 3'd5,
    S_E5  = 3'd6,
    S_HLT = 3'd7
  } state_t;

  state_t     r_state;
  logic       r_f1_first;
  logic       r_illegal;

  logic [4:0] w_op;
  logic [3:0] w_ra, w_rb, w_rc;
  logic       w_is_ld, w_is_st, w_is_alu, w_is_nop, w_is_halt;
  logic       w_waiting, w_timeout;
  logic       w_unused;

  assign w_op      = ir_data[31:27];
  assign w_ra      = ir_data[26:23];
  assign w_rb      = ir_data[22:19];
  assign w_rc      = ir_data[18:15];
  assign w_is_ld   = (w_op == 5'b00000);
  assign w_is_st   = (w_op == 5'b00010);
  assign w_is_alu  = (w_op == 5'b00011) || (w_op == 5'b00100) ||
                     (w_op == 5'b00101) || (w_op == 5'b00110);
  assign w_is_nop  = (w_op == 5'b11010);
  assign w_is_halt = (w_op == 5'b11011);
  assign w_unused  = ^{ir_data[14:0], 5'(TIMEOUT_CYCLES)};

  // The only states that stall on mem_ready.
  assign w_waiting = (r_state == S_F1) ||
                     ((r_state == S_E4) && w_is_ld) ||
                     ((r_state == S_E5) && w_is_st);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_F0;
      r_f1_first <= 1'b1;
      r_illegal  <= 1'b0;
    end else begin
      r_f1_first <= (r_state == S_F0);
      if (w_timeout) begin
        r_state <= S_HLT;
      end else begin
        case (r_state)
          S_F0:  r_state <= S_F1;
          S_F1:  if (mem_ready) r_state <= S_F2;
          S_F2:  r_state <= S_DEC;
          S_DEC: begin
            if (w_is_alu || w_is_ld || w_is_st) begin
              r_state <= S_E3;
            end else if (w_is_nop) begin
              r_state <= S_F0;
            end else begin
              r_state <= S_HLT;
              if (!w_is_halt) r_illegal <= 1'b1;
            end
          end
          S_E3:  r_state <= S_E4;
          S_E4:  if (!w_is_ld || mem_ready) r_state <= S_E5;
          S_E5:  if (!w_is_st || mem_ready) r_state <= S_F0;
          default: r_state <= S_HLT;
        endcase
      end
    end
  end

  always_comb begin
    gpr_in     = '0;
    gpr_out    = '0;
    pc_in      = 1'b0;
    ir_in      = 1'b0;
    z_in       = 1'b0;
    y_in       = 1'b0;
    mar_in     = 1'b0;
    mdr_in     = 1'b0;
    pc_out     = 1'b0;
    z_low_out  = 1'b0;
    mdr_out    = 1'b0;
    read       = 1'b0;
    alu_op     = ALU_ADD;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    instr_done = 1'b0;
    if (!reset) begin
      case (r_state)
        S_F0: begin
          pc_out = 1'b1;
          mar_in = 1'b1;
          alu_op = ALU_INC;
          z_in   = 1'b1;
        end
        S_F1: begin
          z_low_out = 1'b1;
          pc_in     = r_f1_first;
          mem_rd    = 1'b1;
          read      = 1'b1;
          mdr_in    = mem_ready;
        end
        S_F2: begin
          mdr_out = 1'b1;
          ir_in   = 1'b1;
        end
        S_DEC: instr_done = w_is_nop;
        S_E3: begin
          gpr_out = 16'd1 << w_rb;
          y_in    = w_is_alu;
          mar_in  = !w_is_alu;
        end
        S_E4: begin
          if (w_is_alu) begin
            gpr_out = 16'd1 << w_rc;
            z_in    = 1'b1;
            case (w_op)
              5'b00100: alu_op = ALU_SUB;
              5'b00101: alu_op = ALU_AND;
              5'b00110: alu_op = ALU_OR;
              default:  alu_op = ALU_ADD;
            endcase
          end else if (w_is_ld) begin
            mem_rd = 1'b1;
            read   = 1'b1;
            mdr_in = mem_ready;
          end else begin
            gpr_out = 16'd1 << w_ra;
            mdr_in  = 1'b1;
          end
        end
        S_E5: begin
          if (w_is_st) begin
            mem_wr     = 1'b1;
            instr_done = mem_ready;
          end else begin
            gpr_in     = 16'd1 << w_ra;
            z_low_out  = w_is_alu;
            mdr_out    = !w_is_alu;
            instr_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_in      = 1'b0;
  assign lo_in      = 1'b0;
  assign hi_out     = 1'b0;
  assign lo_out     = 1'b0;
  assign z_high_out = 1'b0;
  assign inport_out = 1'b0;
  assign c_out      = 1'b0;
  assign run        = reset || (r_state != S_HLT);
  assign illegal    = r_illegal && !reset;

`ifdef CTRL_WAIT_TIMEOUT_EN
  localparam logic [4:0] c_to_last = 5'(TIMEOUT_CYCLES - 1);

  logic [4:0] r_wcnt;
  logic       r_fault;

  // Counter is held at zero outside wait states, so every wait starts fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt  <= '0;
      r_fault <= 1'b0;
    end else begin
      if (!w_waiting)      r_wcnt <= '0;
      else if (!mem_ready) r_wcnt <= r_wcnt + 5'd1;
      if (w_timeout)       r_fault <= 1'b1;
    end
  end

  assign w_timeout = w_waiting && !mem_ready && (r_wcnt == c_to_last);
  assign fault     = r_fault && !reset;
`else
  assign w_timeout = 1'b0;
  assign fault     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
// ============================================================================
// tb_ctrl_sequencer : table-driven directed bench for ctrl_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_data;
  logic        mem_ready;
  logic [15:0] gpr_in, gpr_out;
  logic        hi_in, lo_in, pc_in, ir_in, z_in, y_in, mar_in, mdr_in;
  logic        hi_out, lo_out, pc_out, z_high_out, z_low_out, mdr_out, inport_out, c_out;
  logic        read, mem_rd, mem_wr, run, instr_done, illegal, fault;
  logic [3:0]  alu_op;

  always #5 clk = ~clk;

  ctrl_sequencer dut (
    .clk(clk), .reset(reset), .ir_data(ir_data), .mem_ready(mem_ready),
    .gpr_in(gpr_in), .gpr_out(gpr_out),
    .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in), .ir_in(ir_in), .z_in(z_in),
    .y_in(y_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .hi_out(hi_out), .lo_out(lo_out), .pc_out(pc_out), .z_high_out(z_high_out),
    .z_low_out(z_low_out), .mdr_out(mdr_out), .inport_out(inport_out), .c_out(c_out),
    .read(read), .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .run(run), .instr_done(instr_done), .illegal(illegal), .fault(fault)
  );

  localparam logic [23:0] RUN = 24'd1 << 0,  DONE = 24'd1 << 1,  ILL = 24'd1 << 2;
  localparam logic [23:0] FLT = 24'd1 << 3,  PCI  = 24'd1 << 4,  IRI = 24'd1 << 5;
  localparam logic [23:0] ZI  = 24'd1 << 6,  YI   = 24'd1 << 7,  MARI = 24'd1 << 8;
  localparam logic [23:0] MDRI = 24'd1 << 9, PCO  = 24'd1 << 10, ZLO = 24'd1 << 11;
  localparam logic [23:0] MDRO = 24'd1 << 12, RD  = 24'd1 << 13, MRD = 24'd1 << 14;
  localparam logic [23:0] MWR = 24'd1 << 15;

  localparam logic [31:0] I_ADD  = 32'h18918000;
  localparam logic [31:0] I_AND  = 32'h2A4F8000;  // AND R4,R9,R15
  localparam logic [31:0] I_LD   = 32'h02B00000;
  localparam logic [31:0] I_ST   = 32'h13C00000;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;
  localparam logic [31:0] I_BAD  = 32'hF8000000;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] ir;
    logic        rdy;
    logic [15:0] gin;
    logic [15:0] gout;
    logic [23:0] fl;
    logic [3:0]  alu;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  logic [23:0] obs;
  assign obs = {1'b0, c_out, inport_out, z_high_out, lo_out, hi_out, lo_in, hi_in,
                mem_wr, mem_rd, read, mdr_out, z_low_out, pc_out, mdr_in, mar_in,
                y_in, z_in, ir_in, pc_in, fault, illegal, instr_done, run};

  task automatic add(input string name, input logic rst, input logic [31:0] ir,
                     input logic rdy, input logic [15:0] gin, input logic [15:0] gout,
                     input logic [23:0] fl, input logic [3:0] alu);
    vec_t v;
    v.name = name; v.rst = rst; v.ir = ir; v.rdy = rdy;
    v.gin = gin; v.gout = gout; v.fl = fl; v.alu = alu;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input string tag, input logic [31:0] ir);
    add({tag, "_f0"}, 1'b0, ir, 1'b1, 16'h0, 16'h0, RUN | PCO | MARI | ZI, 4'd4);
    add({tag, "_f1"}, 1'b0, ir, 1'b1, 16'h0, 16'h0, RUN | ZLO | PCI | MRD | RD | MDRI, 4'd0);
    add({tag, "_f2"}, 1'b0, ir, 1'b1, 16'h0, 16'h0, RUN | MDRO | IRI, 4'd0);
  endtask

  task automatic check(input string name, input logic [15:0] gin, input logic [15:0] gout,
                       input logic [23:0] fl, input logic [3:0] alu);
    checks++;
    if (gpr_in !== gin || gpr_out !== gout || obs !== fl || alu_op !== alu) begin
      errors++;
      $display("FAIL %s: got gpr_in=%h gpr_out=%h flags=%h alu=%0d, expected gpr_in=%h gpr_out=%h flags=%h alu=%0d",
               name, gpr_in, gpr_out, obs, alu_op, gin, gout, fl, alu);
    end
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst; ir_data = v.ir; mem_ready = v.rdy;
    @(negedge clk);
    check(v.name, v.gin, v.gout, v.fl, v.alu);
    @(posedge clk); #1;
  endtask

  task automatic step(input logic rst, input logic [31:0] ir, input logic rdy);
    reset = rst; ir_data = ir; mem_ready = rdy;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; ir_data = 32'h0; mem_ready = 1'b1;
    @(posedge clk); #1;

    add("reset0", 1'b1, I_ADD, 1'b1, 16'h0, 16'h0, RUN, 4'd0);
    add("reset1", 1'b1, I_ADD, 1'b1, 16'h0, 16'h0, RUN, 4'd0);
    add_fetch("add", I_ADD);
    add("add_dec", 1'b0, I_ADD, 1'b1, 16'h0000, 16'h0000, RUN, 4'd0);
    add("add_e3",  1'b0, I_ADD, 1'b1, 16'h0000, 16'h0004, RUN | YI, 4'd0);
    add("add_e4",  1'b0, I_ADD, 1'b1, 16'h0000, 16'h0008, RUN | ZI, 4'd0);
    add("add_e5",  1'b0, I_ADD, 1'b1, 16'h0002, 16'h0000, RUN | ZLO | DONE, 4'd0);
    add_fetch("and", I_AND);
    add("and_dec", 1'b0, I_AND, 1'b1, 16'h0000, 16'h0000, RUN, 4'd0);
    add("and_e3",  1'b0, I_AND, 1'b1, 16'h0000, 16'h0200, RUN | YI, 4'd0);
    add("and_e4",  1'b0, I_AND, 1'b1, 16'h0000, 16'h8000, RUN | ZI, 4'd2);
    add("and_e5",  1'b0, I_AND, 1'b1, 16'h0010, 16'h0000, RUN | ZLO | DONE, 4'd0);
    add("ld_f0",   1'b0, I_LD, 1'b1, 16'h0, 16'h0, RUN | PCO | MARI | ZI, 4'd4);
    add("ld_f1w0", 1'b0, I_LD, 1'b0, 16'h0, 16'h0, RUN | ZLO | PCI | MRD | RD, 4'd0);
    add("ld_f1w1", 1'b0, I_LD, 1'b0, 16'h0, 16'h0, RUN | ZLO | MRD | RD, 4'd0);
    add("ld_f1",   1'b0, I_LD, 1'b1, 16'h0, 16'h0, RUN | ZLO | MRD | RD | MDRI, 4'd0);
    add("ld_f2",   1'b0, I_LD, 1'b1, 16'h0, 16'h0, RUN | MDRO | IRI, 4'd0);
    add("ld_dec",  1'b0, I_LD, 1'b1, 16'h0, 16'h0, RUN, 4'd0);
    add("ld_e3",   1'b0, I_LD, 1'b1, 16'h0, 16'h0040, RUN | MARI, 4'd0);
    for (int i = 0; i < 3; i++)
      add("ld_e4w", 1'b0, I_LD, 1'b0, 16'h0, 16'h0, RUN | MRD | RD, 4'd0);
    add("ld_e4",   1'b0, I_LD, 1'b1, 16'h0, 16'h0, RUN | MRD | RD | MDRI, 4'd0);
    add("ld_e5",   1'b0, I_LD, 1'b1, 16'h0020, 16'h0, RUN | MDRO | DONE, 4'd0);
    add_fetch("st", I_ST);
    add("st_dec",  1'b0, I_ST, 1'b1, 16'h0, 16'h0, RUN, 4'd0);
    add("st_e3",   1'b0, I_ST, 1'b1, 16'h0, 16'h0100, RUN | MARI, 4'd0);
    add("st_e4",   1'b0, I_ST, 1'b0, 16'h0, 16'h0080, RUN | MDRI, 4'd0);
    add("st_e5w",  1'b0, I_ST, 1'b0, 16'h0, 16'h0, RUN | MWR, 4'd0);
    add("st_e5w",  1'b0, I_ST, 1'b0, 16'h0, 16'h0, RUN | MWR, 4'd0);
    add("st_e5",   1'b0, I_ST, 1'b1, 16'h0, 16'h0, RUN | MWR | DONE, 4'd0);
    add_fetch("nop", I_NOP);
    add("nop_dec", 1'b0, I_NOP, 1'b1, 16'h0, 16'h0, RUN | DONE, 4'd0);
    add_fetch("halt", I_HALT);
    add("halt_dec", 1'b0, I_HALT, 1'b1, 16'h0, 16'h0, RUN, 4'd0);

    foreach (vecs[i]) apply(vecs[i]);

    // HALT: quiet and stays put, whatever mem_ready does.
    for (int i = 0; i < 22; i++) begin
      reset = 1'b0; ir_data = I_HALT; mem_ready = i[0];
      @(negedge clk);
      check("halt_hold", 16'h0, 16'h0, 24'h0, 4'd0);
      @(posedge clk); #1;
    end

    // Reset pulse restarts at F0.
    step(1'b1, I_BAD, 1'b1);
    reset = 1'b0; @(negedge clk);
    check("restart_f0", 16'h0, 16'h0, RUN | PCO | MARI | ZI, 4'd4);
    @(posedge clk); #1;

    // Illegal opcode halts with sticky illegal.
    step(1'b0, I_BAD, 1'b1);
    step(1'b0, I_BAD, 1'b1);
    @(negedge clk);
    check("bad_dec", 16'h0, 16'h0, RUN, 4'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bad_hlt", 16'h0, 16'h0, ILL, 4'd0);
      @(posedge clk); #1;
    end

    // Reset mid-instruction clears illegal and suppresses strobes.
    reset = 1'b1; @(negedge clk);
    check("ill_reset", 16'h0, 16'h0, RUN, 4'd0);
    @(posedge clk); #1;
    step(1'b0, I_ADD, 1'b1);
    step(1'b0, I_ADD, 1'b1);
    reset = 1'b1; @(negedge clk);
    check("abort_reset", 16'h0, 16'h0, RUN, 4'd0);
    @(posedge clk); #1;

    // Memory never ready during fetch.
    step(1'b0, I_ADD, 1'b0);
`ifdef CTRL_WAIT_TIMEOUT_EN
    for (int i = 0; i < 16; i++) step(1'b0, I_ADD, 1'b0);
    @(negedge clk);
    check("timeout_fault", 16'h0, 16'h0, FLT, 4'd0);
`else
    for (int i = 0; i < 100; i++) step(1'b0, I_ADD, 1'b0);
    @(negedge clk);
    check("no_timeout", 16'h0, 16'h0, RUN | ZLO | MRD | RD, 4'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
